// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries with flush; head is
// read straight from the storage array so it is valid whenever count != 0.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  fetch_entry_t     push_data,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic             do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count      <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= next_ptr(wr_ptr_reg);
         end
         if (do_pop) begin
            rd_ptr_reg <= next_ptr(rd_ptr_reg);
         end
         if (push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (!push && do_pop) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // The request credit scheme upstream must never let the buffer overflow.
   assert property (@(posedge clk) disable iff (reset || flush)
                    !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited imem requests, in-order response
// buffering, branch redirect with kill of in-flight responses.
// Optional FETCH_PERF_EN adds perf_fetched / perf_killed counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out,
   output logic        inst_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_killed
`endif
);

   localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

   logic [31:0]      fetch_pc_reg;
   logic [31:0]      resp_pc_reg;
   logic [CNT_W-1:0] outstanding_reg;
   logic [CNT_W-1:0] kill_cnt_reg;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   in_use;
   logic             grant;
   logic             accept;
   logic             drop;
   logic             pop;
   logic [31:0]      target_aligned;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;

   // Killed responses still occupy a credit until they return.
   assign in_use         = {1'b0, outstanding_reg} + {1'b0, count};
   assign imem_req       = !reset && !br_taken && (in_use < DEPTH_LIM);
   assign imem_addr      = fetch_pc_reg;
   assign grant          = imem_req && imem_gnt;
   assign accept         = imem_rvalid && !reset && !br_taken && (kill_cnt_reg == '0);
   assign drop           = imem_rvalid && !reset && !br_taken && (kill_cnt_reg != '0);
   assign inst_valid     = (count != '0);
   assign pop            = inst_valid && !stall && !br_taken;
   assign target_aligned = align_word(br_target);
   assign push_entry     = '{pc: resp_pc_reg, inst: imem_rdata};
   assign pc_out         = inst_valid ? head.pc : 32'h0;
   assign inst_out       = inst_valid ? head.inst : NOP_INST;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg    <= align_word(RESET_PC);
         resp_pc_reg     <= align_word(RESET_PC);
         outstanding_reg <= '0;
         kill_cnt_reg    <= '0;
      end else begin
         if (grant && !imem_rvalid) begin
            outstanding_reg <= outstanding_reg + CNT_W'(1);
         end else if (!grant && imem_rvalid) begin
            outstanding_reg <= outstanding_reg - CNT_W'(1);
         end

         if (br_taken) begin
            fetch_pc_reg <= target_aligned;
            resp_pc_reg  <= target_aligned;
            // Everything still in flight after this cycle belongs to the old path.
            kill_cnt_reg <= outstanding_reg - CNT_W'(imem_rvalid);
         end else begin
            if (grant) begin
               fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end
            if (accept) begin
               resp_pc_reg <= resp_pc_reg + 32'd4;
            end
            if (drop) begin
               kill_cnt_reg <= kill_cnt_reg - CNT_W'(1);
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (accept),
      .push_data(push_entry),
      .pop      (pop),
      .flush    (br_taken),
      .head     (head),
      .count    (count)
   );

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_killed  <= '0;
      end else begin
         if (accept) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (drop) begin
            perf_killed <= perf_killed + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with an in-order, 1-cycle-latency
// instruction memory model whose responses can be held back.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC   = 32'h0000_0000;
   localparam logic [31:0] DATA_OFS = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        inst_valid;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_killed;
`endif

   int          checks = 0;
   int          errors = 0;
   logic        mem_en = 1'b1;
   logic [31:0] exp_fetch;
   logic [31:0] exp_pop;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC  (RST_PC),
      .FIFO_DEPTH(2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .pc_out     (pc_out),
      .inst_out   (inst_out),
      .inst_valid (inst_valid)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_killed (perf_killed)
`endif
   );

   // Memory model: word at address A reads as A + DATA_OFS.
   logic [31:0] mq [$];
   logic        s_grant = 1'b0;
   logic        s_rvalid = 1'b0;
   logic        s_reset = 1'b1;
   logic        s_en = 1'b1;
   logic [31:0] s_addr = 32'h0;

   always @(negedge clk) begin
      s_grant  = imem_req && imem_gnt;
      s_addr   = imem_addr;
      s_rvalid = imem_rvalid;
      s_reset  = reset;
      s_en     = mem_en;
   end

   always @(posedge clk) begin
      #1;
      if (s_reset) begin
         mq.delete();
      end else begin
         if (s_rvalid && mq.size() > 0) mq.delete(0);
         if (s_grant) mq.push_back(s_addr);
      end
      imem_rvalid = s_en && !s_reset && (mq.size() > 0);
      imem_rdata  = (mq.size() > 0) ? mq[0] + DATA_OFS : 32'h0;
   end

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req);
      checks++;
      if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", inst_valid);
      checks++;
      if (inst_out !== NOP_INST) $display("FAIL reset_inst: got %h expected %h", inst_out, NOP_INST);
      checks++;
      if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h expected 0", pc_out);
      checks++;
      if (imem_addr !== RST_PC) $display("FAIL reset_addr: got %h expected %h", imem_addr, RST_PC);
      errors = errors + (imem_req !== 1'b0) + (inst_valid !== 1'b0) + (inst_out !== NOP_INST)
                      + (pc_out !== 32'h0) + (imem_addr !== RST_PC);
      $display("test_reset: req=%b valid=%b inst=%h pc=%h", imem_req, inst_valid, inst_out, pc_out);
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      int pops = 0;
      int first_resp = -1;
      reset = 1'b0;
      exp_fetch = RST_PC;
      exp_pop = RST_PC;
      for (int c = 0; c < 40 && pops < 6; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
               errors++;
               $display("FAIL stream_first_req: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RST_PC);
            end
         end
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL stream_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (first_resp < 0 && imem_rvalid) begin
            first_resp = c;
            checks++;
            if (inst_valid !== 1'b0) begin
               errors++;
               $display("FAIL stream_bypass: inst_valid=%b in response cycle, expected 0", inst_valid);
            end
         end else if (first_resp >= 0 && c == first_resp + 1) begin
            checks++;
            if (inst_valid !== 1'b1) begin
               errors++;
               $display("FAIL stream_latency: inst_valid=%b cycle after response, expected 1", inst_valid);
            end
         end
         if (inst_valid && !stall && !br_taken) begin
            checks++;
            if (pc_out !== exp_pop || inst_out !== exp_pop + DATA_OFS) begin
               errors++;
               $display("FAIL stream_pop: pc=%h inst=%h expected pc=%h inst=%h", pc_out, inst_out, exp_pop, exp_pop + DATA_OFS);
            end
            exp_pop += 32'd4;
            pops++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (pops < 6) begin
         errors++;
         $display("FAIL stream_timeout: pops=%0d expected 6", pops);
      end
      $display("test_stream: %0d instructions delivered, next fetch %h", pops, exp_fetch);
   endtask

   task automatic test_stall();
      int pops = 0;
      stall = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL stall_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (c >= 2) begin
            checks++;
            if (imem_req !== 1'b0) begin
               errors++;
               $display("FAIL stall_req_full: cycle %0d req=%b expected 0", c, imem_req);
            end
         end
         if (inst_valid) begin
            checks++;
            if (pc_out !== exp_pop || inst_out !== exp_pop + DATA_OFS) begin
               errors++;
               $display("FAIL stall_head: pc=%h inst=%h expected pc=%h inst=%h", pc_out, inst_out, exp_pop, exp_pop + DATA_OFS);
            end
         end
         if (c == 4) begin
            checks++;
            if (inst_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_valid: got %b expected 1", inst_valid);
            end
         end
         @(posedge clk);
         #1;
      end
      stall = 1'b0;
      for (int c = 0; c < 30 && pops < 4; c++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL stall_rel_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (inst_valid && !stall && !br_taken) begin
            checks++;
            if (pc_out !== exp_pop || inst_out !== exp_pop + DATA_OFS) begin
               errors++;
               $display("FAIL stall_rel_pop: pc=%h inst=%h expected pc=%h", pc_out, inst_out, exp_pop);
            end
            exp_pop += 32'd4;
            pops++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (pops < 4) begin
         errors++;
         $display("FAIL stall_timeout: pops=%0d expected 4", pops);
      end
      $display("test_stall: held 5 cycles, %0d delivered after release", pops);
   endtask

   task automatic test_branch_kill();
      int pops = 0;
      logic [31:0] killed_before;
      mem_en = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL kill_drain_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (inst_valid && !stall && !br_taken) begin
            checks++;
            if (pc_out !== exp_pop) begin
               errors++;
               $display("FAIL kill_drain_pop: pc=%h expected %h", pc_out, exp_pop);
            end
            exp_pop += 32'd4;
         end
         if (c == 7) begin
            checks++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0 || mq.size() != 2) begin
               errors++;
               $display("FAIL kill_setup: req=%b valid=%b pending=%0d expected 0 0 2", imem_req, inst_valid, mq.size());
            end
         end
         @(posedge clk);
         #1;
      end
      killed_before = 32'h0;
`ifdef FETCH_PERF_EN
      killed_before = perf_killed;
`endif
      br_taken = 1'b1;
      br_target = 32'h0000_0100;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL kill_br_req: got %b expected 0", imem_req);
      end
      @(posedge clk);
      #1;
      br_taken = 1'b0;
      mem_en = 1'b1;
      exp_fetch = 32'h0000_0100;
      exp_pop = 32'h0000_0100;
      for (int c = 0; c < 20 && pops < 2; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (imem_addr !== 32'h0000_0100) begin
               errors++;
               $display("FAIL kill_redirect_addr: got %h expected 00000100", imem_addr);
            end
         end
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL kill_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (inst_valid && !stall && !br_taken) begin
            checks++;
            if (pc_out !== exp_pop || inst_out !== exp_pop + DATA_OFS) begin
               errors++;
               $display("FAIL kill_pop: pc=%h inst=%h expected pc=%h inst=%h", pc_out, inst_out, exp_pop, exp_pop + DATA_OFS);
            end
            exp_pop += 32'd4;
            pops++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (pops < 2) begin
         errors++;
         $display("FAIL kill_timeout: pops=%0d expected 2", pops);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_killed - killed_before !== 32'd2) begin
         errors++;
         $display("FAIL perf_killed: delta %0d expected 2", perf_killed - killed_before);
      end
`endif
      $display("test_branch_kill: target 00000100, killed_before=%0d, %0d delivered", killed_before, pops);
   endtask

   task automatic test_misaligned();
      int pops = 0;
      br_taken = 1'b1;
      br_target = 32'h0000_0203;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL mis_br_req: got %b expected 0", imem_req);
      end
      @(posedge clk);
      #1;
      br_taken = 1'b0;
      exp_fetch = 32'h0000_0200;
      exp_pop = 32'h0000_0200;
      for (int c = 0; c < 20 && pops < 2; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (imem_addr !== 32'h0000_0200) begin
               errors++;
               $display("FAIL mis_addr_align: got %h expected 00000200", imem_addr);
            end
         end
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL mis_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (inst_valid && !stall && !br_taken) begin
            checks++;
            if (pc_out !== exp_pop || inst_out !== exp_pop + DATA_OFS) begin
               errors++;
               $display("FAIL mis_pop: pc=%h inst=%h expected pc=%h", pc_out, inst_out, exp_pop);
            end
            exp_pop += 32'd4;
            pops++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (pops < 2) begin
         errors++;
         $display("FAIL mis_timeout: pops=%0d expected 2", pops);
      end
      $display("test_misaligned: target 00000203 -> fetch from 00000200, %0d delivered", pops);
   endtask

   task automatic test_branch_stall_full();
      logic seen = 1'b0;
      stall = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL bsf_fill_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (c == 5) begin
            checks++;
            if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
               errors++;
               $display("FAIL bsf_full: valid=%b req=%b expected 1 0", inst_valid, imem_req);
            end
         end
         @(posedge clk);
         #1;
      end
      br_taken = 1'b1;
      br_target = 32'h0000_0300;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL bsf_br_req: got %b expected 0", imem_req);
      end
      @(posedge clk);
      #1;
      br_taken = 1'b0;
      exp_fetch = 32'h0000_0300;
      exp_pop = 32'h0000_0300;
      for (int c = 0; c < 15 && !seen; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (inst_valid !== 1'b0) begin
               errors++;
               $display("FAIL bsf_flush: inst_valid=%b expected 0", inst_valid);
            end
         end
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL bsf_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         checks++;
         if (inst_valid) begin
            seen = 1'b1;
            if (pc_out !== exp_pop || inst_out !== exp_pop + DATA_OFS) begin
               errors++;
               $display("FAIL bsf_new_head: pc=%h inst=%h expected pc=%h", pc_out, inst_out, exp_pop);
            end
         end else if (inst_out !== NOP_INST || pc_out !== 32'h0) begin
            errors++;
            $display("FAIL bsf_empty_out: inst=%h pc=%h expected %h 00000000", inst_out, pc_out, NOP_INST);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL bsf_timeout: no instruction from 00000300");
      end
      $display("test_branch_stall_full: flushed, new head from 00000300 seen=%b", seen);
   endtask

   task automatic test_reset_mid();
      int pops = 0;
      logic found = 1'b0;
      stall = 1'b0;
      br_taken = 1'b1;
      br_target = 32'h0000_0020;
      @(posedge clk);
      #1;
      br_taken = 1'b0;
      exp_fetch = 32'h0000_0020;
      exp_pop = 32'h0000_0020;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL rmid_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (inst_valid && !stall && !br_taken) begin
            checks++;
            if (pc_out !== exp_pop) begin
               errors++;
               $display("FAIL rmid_pop: pc=%h expected %h", pc_out, exp_pop);
            end
            exp_pop += 32'd4;
         end
         if (imem_addr == 32'h0000_0040) found = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rmid_timeout: fetch_pc never reached 00000040");
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rmid_req: got %b expected 0", imem_req);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_out !== NOP_INST
          || pc_out !== 32'h0 || imem_addr !== RST_PC) begin
         errors++;
         $display("FAIL rmid_outputs: req=%b valid=%b inst=%h pc=%h addr=%h expected 0 0 %h 00000000 %h",
                  imem_req, inst_valid, inst_out, pc_out, imem_addr, NOP_INST, RST_PC);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== 32'h0 || perf_killed !== 32'h0) begin
         errors++;
         $display("FAIL rmid_perf: fetched=%0d killed=%0d expected 0 0", perf_fetched, perf_killed);
      end
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_fetch = RST_PC;
      exp_pop = RST_PC;
      for (int c = 0; c < 30 && pops < 3; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
               errors++;
               $display("FAIL rmid_restart: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC);
            end
         end
         if (imem_req && imem_gnt) begin
            checks++;
            if (imem_addr !== exp_fetch) begin
               errors++;
               $display("FAIL rmid_re_addr: got %h expected %h", imem_addr, exp_fetch);
            end
            exp_fetch += 32'd4;
         end
         if (inst_valid && !stall && !br_taken) begin
            checks++;
            if (pc_out !== exp_pop || inst_out !== exp_pop + DATA_OFS) begin
               errors++;
               $display("FAIL rmid_re_pop: pc=%h inst=%h expected pc=%h", pc_out, inst_out, exp_pop);
            end
            exp_pop += 32'd4;
            pops++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (pops < 3) begin
         errors++;
         $display("FAIL rmid_re_timeout: pops=%0d expected 3", pops);
      end
      $display("test_reset_mid: reset at fetch 00000040, restart delivered %0d", pops);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch_kill();
      test_misaligned();
      test_branch_stall_full();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, 2, instruction buffer entries and maximum outstanding requests; legal range 2..8.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  downstream cannot accept; the head entry is held.
REQ-006 br_taken  in  1  redirect fetch; flush the buffer and in-flight work.
REQ-007 br_target  in  32  redirect address, sampled when br_taken=1.
REQ-008 imem_req  out  1  instruction memory request valid.
REQ-009 imem_addr  out  32  request address; always word-aligned.
REQ-010 imem_gnt  in  1  request accepted in the cycle imem_req&imem_gnt.
REQ-011 imem_rvalid  in  1  response valid; in order, at least 1 cycle after grant.
REQ-012 imem_rdata  in  32  response instruction word.
REQ-013 pc_out  out  32  PC of the head instruction.
REQ-014 inst_out  out  32  head instruction; 32'h00000013 (NOP) when the buffer is empty.
REQ-015 inst_valid  out  1  buffer non-empty.

Function
REQ-016 imem_req=1 iff !reset && !br_taken && (outstanding+count < FIFO_DEPTH); a same-cycle pop gives no credit.
REQ-017 imem_addr = fetch_pc; fetch_pc += 4 on each grant, wrapping modulo 2^32.
REQ-018 outstanding increments on grant and decrements on rvalid; simultaneous grant and rvalid leaves it unchanged.
REQ-019 Accepted response (kill_cnt==0, !br_taken): push {resp_pc, imem_rdata}; resp_pc += 4.
REQ-020 Pop head when inst_valid && !stall && !br_taken; push and pop in the same cycle leave count unchanged.
REQ-021 Latency: response in cycle N -> inst_valid=1 in cycle N+1 (registered buffer, no bypass).
REQ-022 br_taken cycle: count<=0; fetch_pc<=br_target&~3; resp_pc<=br_target&~3; kill_cnt<=outstanding-(imem_rvalid?1:0).
REQ-023 br_taken cycle: any imem_rvalid in that cycle is discarded.
REQ-024 Response with kill_cnt>0 is dropped and kill_cnt decrements; drops still decrement outstanding.
REQ-025 br_taken during stall: br_taken wins; buffer flushed.
REQ-026 Back-to-back br_taken: the last target wins; kill_cnt is recomputed each cycle per REQ-022.
REQ-027 Buffer overflow is impossible by REQ-016; a push with count==FIFO_DEPTH is a design error flagged by assertion.

Reset
REQ-028 Reset values: fetch_pc=resp_pc=RESET_PC; count=outstanding=kill_cnt=0; imem_req=0; inst_valid=0; inst_out=NOP; pc_out=0.
REQ-029 Reset mid-operation discards the buffer and all in-flight state; imem shares reset, so no stale responses follow.
REQ-030 Reset has priority over br_taken, stall and all responses.

Configuration
REQ-031 Macro FETCH_PERF_EN: when defined, add outputs perf_fetched[31:0] (accepted pushes) and perf_killed[31:0] (dropped responses); both reset to 0 and wrap.
REQ-032 Without FETCH_PERF_EN, these ports and counters do not exist, and function is otherwise identical.

Structure
REQ-033 Package fetch_pkg holds NOP_INST=32'h00000013, DEFAULT_RESET_PC, and struct fetch_entry_t {pc[31:0], inst[31:0]}.
REQ-034 Sub-module fetch_fifo: synchronous, parameterised depth of fetch_entry_t, with push/pop/flush/count ports.

Verification
REQ-035 Reset release, memory with 1-cycle latency, no stall -> addresses 0,4,8,...; pc_out 0,4,8 in order; inst_valid from cycle 3.
REQ-036 Stall held for 5 cycles with DEPTH=2 -> at most 2 outstanding+buffered; imem_req=0 once full; head unchanged; no loss on release.
REQ-037 br_taken target 0x100 with 2 outstanding -> next 2 responses dropped; next pc_out=0x100; with FETCH_PERF_EN, perf_killed=2.
REQ-038 br_taken target 0x203 -> imem_addr=0x200 and pc_out=0x200.
REQ-039 br_taken and stall asserted together with a full buffer -> count=0 next cycle; inst_out=0x00000013 and inst_valid=0 until the new response.
REQ-040 Reset asserted mid-stream at fetch_pc=0x40 -> next cycle imem_req=0 and all outputs at reset values; fetch restarts at RESET_PC.
